// File: rtl/led_matrix_scanner.sv
// rtl/led_matrix_scanner.sv - row-scanned LED matrix driver with double-buffered frame store
// Optional PWM brightness enabled by defining LED_MATRIX_PWM_EN.
module led_matrix_scanner #(
  parameter int ROWS         = 9,
  parameter int COLS         = 8,
  parameter int SCAN_CYCLES  = 27000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                      sys_clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [$clog2(ROWS)-1:0]   wr_row,
  input  logic [COLS-1:0]           wr_data,
  input  logic                      swap_req,
  input  logic [3:0]                bright,
  output logic                      swap_done,
  output logic                      frame_start,
  output logic [ROWS-1:0]           led_row,
  output logic [COLS-1:0]           led_col
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(SCAN_CYCLES);

  logic [CW-1:0]   cnt;
  logic [RW-1:0]   row_idx;
  logic            disp_bank;
  logic            pending;
  logic [COLS-1:0] bank [2][ROWS];

  logic            cnt_wrap;
  logic            last_row;
  logic            boundary;
  logic            do_swap;
  logic            blank;
  logic            wr_ok;
  logic            lit;
  logic [COLS-1:0] row_pat;

  always_comb begin
    cnt_wrap = (int'(cnt) == SCAN_CYCLES - 1);
    last_row = (int'(row_idx) == ROWS - 1);
    boundary = cnt_wrap && last_row;
    do_swap  = boundary && (pending || swap_req);
    blank    = (int'(cnt) < BLANK_CYCLES);
    wr_ok    = wr_en && (int'(wr_row) < ROWS);
    row_pat  = bank[disp_bank][row_idx];
  end

`ifdef LED_MATRIX_PWM_EN
  logic [3:0] pwm_cnt;

  // PWM phase only advances in the active window and restarts every slot
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else if (cnt_wrap) begin
      pwm_cnt <= '0;
    end else if (!blank) begin
      pwm_cnt <= (pwm_cnt == 4'd14) ? 4'd0 : pwm_cnt + 4'd1;
    end
  end

  assign lit = (pwm_cnt < bright);
`else
  logic unused_bright;
  assign unused_bright = ^bright;
  assign lit = 1'b1;
`endif

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      row_idx     <= '0;
      disp_bank   <= 1'b0;
      pending     <= 1'b0;
      led_row     <= '0;
      led_col     <= '0;
      swap_done   <= 1'b0;
      frame_start <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        bank[0][r] <= '0;
        bank[1][r] <= '0;
      end
    end else begin
      cnt <= cnt_wrap ? '0 : cnt + 1'b1;
      if (cnt_wrap) begin
        row_idx <= last_row ? '0 : row_idx + 1'b1;
      end
      if (do_swap) begin
        disp_bank <= ~disp_bank;
        pending   <= 1'b0;
      end else if (swap_req) begin
        pending   <= 1'b1;
      end
      // Uses the pre-swap bank select, so a write in the swap cycle is displayed next
      if (wr_ok) begin
        bank[~disp_bank][wr_row] <= wr_data;
      end
      led_row     <= ROWS'(1) << row_idx;
      led_col     <= (blank || !lit) ? '0 : row_pat;
      frame_start <= (cnt == '0) && (row_idx == '0);
      swap_done   <= do_swap;
    end
  end

endmodule
